if_fetch: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register consumed by the decode stage (`{PCP1,instr}`). Accepts the decode-stage redirect (`JPC`/`jpcAvail`) and the decode stall, squashing wrong-path fetches, including requests already in flight.

---
 rtl/if_fetch.sv | 175 +++++++++++++++++
 tb/tb_if_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage; owns the fetch PC, issues imem word requests, drives IF/ID.
// Latency: an ack in cycle t loads IF/ID at the edge ending t; zero-wait memory sustains one instruction per cycle.
// Backpressure: IF_STALL holds IF/ID (an acked word parks in hbuf); redirects squash in-flight fetches via DROP.
// Optional build macro IF_PERF_CNT_EN adds o_fetch_cnt / o_squash_cnt.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_STALL,
  input  logic [29:0] i_JPC,
  input  logic        i_jpcAvail,
  output logic        o_imem_req,
  output logic [29:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [61:0] o_ID_DATA,
  output logic        o_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [29:0] r_fa;
  logic [29:0] w_fa_nxt;
  logic [29:0] r_tgt;
  logic [29:0] w_tgt_nxt;
  logic [31:0] r_hbuf;
  logic [31:0] w_hbuf_nxt;
  logic [61:0] r_id_data;
  logic [61:0] w_id_data_nxt;
  logic        r_id_valid;
  logic        w_id_valid_nxt;
  logic        w_req;
  logic        w_redir;
  logic [29:0] w_fa_p1;
  logic        w_fetch_inc;
  logic        w_squash_inc;

  // A redirect is only honoured when decode is not stalled; fa+1 wraps modulo 2^30.
  assign w_redir = i_jpcAvail & ~IF_STALL;
  assign w_fa_p1 = r_fa + 30'd1;

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fa;
  assign o_ID_DATA   = r_id_data;
  assign o_ID_valid  = r_id_valid;

  // Next-state, request and IF/ID load decisions for every state/ack/stall/redirect combination.
  always_comb begin
    w_state_nxt    = r_state;
    w_fa_nxt       = r_fa;
    w_tgt_nxt      = r_tgt;
    w_hbuf_nxt     = r_hbuf;
    w_id_data_nxt  = r_id_data;
    w_id_valid_nxt = r_id_valid;
    w_req          = 1'b0;
    w_fetch_inc    = 1'b0;
    w_squash_inc   = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        w_req = 1'b1;
        if (i_imem_ack) begin
          if (IF_STALL) begin
            // Park the word; fa still names it so the release can form PCP1.
            w_hbuf_nxt  = i_imem_rdata;
            w_state_nxt = S_HOLD;
          end else if (w_redir) begin
            w_id_data_nxt  = 62'd0;
            w_id_valid_nxt = 1'b0;
            w_fa_nxt       = i_JPC;
            w_squash_inc   = 1'b1;
          end else begin
            w_id_data_nxt  = {w_fa_p1, i_imem_rdata};
            w_id_valid_nxt = 1'b1;
            w_fa_nxt       = w_fa_p1;
            w_fetch_inc    = 1'b1;
          end
        end else if (!IF_STALL) begin
          w_id_data_nxt  = 62'd0;
          w_id_valid_nxt = 1'b0;
          if (w_redir) begin
            // Address must stay put until ack, so remember the target and drain.
            w_tgt_nxt   = i_JPC;
            w_state_nxt = S_DROP;
          end
        end
      end
      S_HOLD: begin
        if (!IF_STALL) begin
          w_state_nxt = S_FETCH;
          if (w_redir) begin
            w_id_data_nxt  = 62'd0;
            w_id_valid_nxt = 1'b0;
            w_fa_nxt       = i_JPC;
            w_squash_inc   = 1'b1;
          end else begin
            w_id_data_nxt  = {w_fa_p1, r_hbuf};
            w_id_valid_nxt = 1'b1;
            w_fa_nxt       = w_fa_p1;
            w_fetch_inc    = 1'b1;
          end
        end
      end
      S_DROP: begin
        w_req = 1'b1;
        if (!IF_STALL) begin
          w_id_data_nxt  = 62'd0;
          w_id_valid_nxt = 1'b0;
          if (w_redir) w_tgt_nxt = i_JPC;
        end
        if (i_imem_ack) begin
          w_fa_nxt     = w_redir ? i_JPC : r_tgt;
          w_state_nxt  = S_FETCH;
          w_squash_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fa       <= RESET_PC[31:2];
      r_tgt      <= 30'd0;
      r_hbuf     <= 32'd0;
      r_id_data  <= 62'd0;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fa       <= w_fa_nxt;
      r_tgt      <= w_tgt_nxt;
      r_hbuf     <= w_hbuf_nxt;
      r_id_data  <= w_id_data_nxt;
      r_id_valid <= w_id_valid_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;

  assign o_fetch_cnt  = r_fetch_cnt;
  assign o_squash_cnt = r_squash_cnt;

  // Free-running wrap-around counters of valid IF/ID loads and discarded acked words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= 32'd0;
      r_squash_cnt <= 32'd0;
    end else begin
      if (w_fetch_inc)  r_fetch_cnt  <= r_fetch_cnt + 32'd1;
      if (w_squash_inc) r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end
`else
  logic w_unused_cnt;
  assign w_unused_cnt = w_fetch_inc ^ w_squash_inc;
`endif

endmodule

// File: tb/tb_if_fetch.sv
`timescale 1ns/1ps
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [29:0] jpc = 30'd0;
  logic        jpc_av = 1'b0;
  logic        req, ack;
  logic [29:0] addr;
  logic [31:0] rdata;
  logic [61:0] id;
  logic        idv;
  logic        req2, ack2;
  logic [29:0] addr2;
  logic [31:0] rdata2;
  logic [61:0] id2;
  logic        idv2;
  int          wait_st = 0;
  int          wcnt = 0;
  int          n_chk = 0;
  int          n_pass = 0;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fcnt, scnt, fcnt2, scnt2;
`endif

  always #5 clk = ~clk;

  // Memory model: returns {2'b0, addr}, acks after wait_st wait cycles.
  assign ack   = req && (wcnt >= wait_st);
  assign rdata = {2'b00, addr};
  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (req && !ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Second instance: zero-wait memory, wrap-around reset PC.
  assign ack2   = req2;
  assign rdata2 = {2'b00, addr2};

  if_fetch dut (
    .clk(clk), .rst(rst), .IF_STALL(stall), .i_JPC(jpc), .i_jpcAvail(jpc_av),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
    .o_ID_DATA(id), .o_ID_valid(idv)
`ifdef IF_PERF_CNT_EN
    , .o_fetch_cnt(fcnt), .o_squash_cnt(scnt)
`endif
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .IF_STALL(1'b0), .i_JPC(30'd0), .i_jpcAvail(1'b0),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_ack(ack2), .i_imem_rdata(rdata2),
    .o_ID_DATA(id2), .o_ID_valid(idv2)
`ifdef IF_PERF_CNT_EN
    , .o_fetch_cnt(fcnt2), .o_squash_cnt(scnt2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; jpc_av = 1'b0; wait_st = 0;
    tick(); tick();
    n_chk++; if (req !== 1'b0) $display("FAIL rst_req: got %h want 0", req); else n_pass++;
    n_chk++; if (addr !== 30'hC00) $display("FAIL rst_addr: got %h want c00", addr); else n_pass++;
    n_chk++; if (id !== 62'd0) $display("FAIL rst_id: got %h want 0", id); else n_pass++;
    n_chk++; if (idv !== 1'b0) $display("FAIL rst_valid: got %h want 0", idv); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (req !== 1'b0) $display("FAIL idle_req: got %h want 0", req); else n_pass++;
    tick();
    n_chk++; if (req !== 1'b1) $display("FAIL first_req: got %h want 1", req); else n_pass++;
    n_chk++; if (addr !== 30'hC00) $display("FAIL first_addr: got %h want c00", addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [29:0] a;
    logic [61:0] e;
    for (int i = 0; i < 3; i++) begin
      tick();
      a = 30'hC00 + 30'(i);
      e = {a + 30'd1, 2'b00, a};
      n_chk++; if (id !== e) $display("FAIL zw_id%0d: got %h want %h", i, id, e); else n_pass++;
      n_chk++; if (idv !== 1'b1) $display("FAIL zw_valid%0d: got %h want 1", i, idv); else n_pass++;
      n_chk++; if (addr !== a + 30'd1) $display("FAIL zw_addr%0d: got %h want %h", i, addr, a + 30'd1); else n_pass++;
    end
  endtask

  task automatic test_stall_hold();
    logic [61:0] held;
    logic [61:0] rel;
    held = {30'hC03, 32'h0000_0C02};
    rel  = {30'hC04, 32'h0000_0C03};
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_chk++; if (req !== 1'b0) $display("FAIL hold_req%0d: got %h want 0", i, req); else n_pass++;
      n_chk++; if (id !== held) $display("FAIL hold_id%0d: got %h want %h", i, id, held); else n_pass++;
      n_chk++; if (idv !== 1'b1) $display("FAIL hold_valid%0d: got %h want 1", i, idv); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_chk++; if (id !== rel) $display("FAIL release_id: got %h want %h", id, rel); else n_pass++;
    n_chk++; if (req !== 1'b1) $display("FAIL release_req: got %h want 1", req); else n_pass++;
    n_chk++; if (addr !== 30'hC04) $display("FAIL release_addr: got %h want c04", addr); else n_pass++;
  endtask

  task automatic test_redirect_ack();
    tick();
    n_chk++; if (addr !== 30'hC05) $display("FAIL pre_redir_addr: got %h want c05", addr); else n_pass++;
    jpc = 30'h1000; jpc_av = 1'b1;
    tick();
    jpc_av = 1'b0;
    n_chk++; if (id !== 62'd0) $display("FAIL redir_id: got %h want 0", id); else n_pass++;
    n_chk++; if (idv !== 1'b0) $display("FAIL redir_valid: got %h want 0", idv); else n_pass++;
    n_chk++; if (addr !== 30'h1000) $display("FAIL redir_addr: got %h want 1000", addr); else n_pass++;
    n_chk++; if (req !== 1'b1) $display("FAIL redir_req: got %h want 1", req); else n_pass++;
  endtask

  task automatic test_drop();
    wait_st = 3;
    jpc = 30'h2000; jpc_av = 1'b1;
    #1;
    n_chk++; if (ack !== 1'b0) $display("FAIL drop_noack: got %h want 0", ack); else n_pass++;
    tick();
    jpc_av = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (addr !== 30'h1000) $display("FAIL drop_addr%0d: got %h want 1000", i, addr); else n_pass++;
      n_chk++; if (req !== 1'b1) $display("FAIL drop_req%0d: got %h want 1", i, req); else n_pass++;
      n_chk++; if (idv !== 1'b0) $display("FAIL drop_valid%0d: got %h want 0", i, idv); else n_pass++;
      if (i < 2) tick();
    end
    tick();
    n_chk++; if (addr !== 30'h2000) $display("FAIL drop_tgt_addr: got %h want 2000", addr); else n_pass++;
    n_chk++; if (id !== 62'd0) $display("FAIL drop_id: got %h want 0", id); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (idv !== 1'b0) $display("FAIL wait_valid%0d: got %h want 0", i, idv); else n_pass++;
    end
    tick();
    n_chk++; if (id !== {30'h2001, 32'h0000_2000}) $display("FAIL tgt_id: got %h want %h", id, {30'h2001, 32'h0000_2000}); else n_pass++;
    n_chk++; if (idv !== 1'b1) $display("FAIL tgt_valid: got %h want 1", idv); else n_pass++;
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    n_chk++; if (fcnt !== 32'd6) $display("FAIL fetch_cnt: got %0d want 6", fcnt); else n_pass++;
    n_chk++; if (scnt !== 32'd2) $display("FAIL squash_cnt: got %0d want 2", scnt); else n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    n_chk++; if (req !== 1'b0) $display("FAIL arst_req: got %h want 0", req); else n_pass++;
    n_chk++; if (idv !== 1'b0) $display("FAIL arst_valid: got %h want 0", idv); else n_pass++;
    n_chk++; if (id !== 62'd0) $display("FAIL arst_id: got %h want 0", id); else n_pass++;
    n_chk++; if (addr !== 30'hC00) $display("FAIL arst_addr: got %h want c00", addr); else n_pass++;
`ifdef IF_PERF_CNT_EN
    n_chk++; if (fcnt !== 32'd0) $display("FAIL arst_fcnt: got %0d want 0", fcnt); else n_pass++;
    n_chk++; if (scnt !== 32'd0) $display("FAIL arst_scnt: got %0d want 0", scnt); else n_pass++;
`endif
    wait_st = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    tick();
    n_chk++; if (req2 !== 1'b1) $display("FAIL wrap_req: got %h want 1", req2); else n_pass++;
    n_chk++; if (addr2 !== 30'h3FFF_FFFF) $display("FAIL wrap_addr0: got %h want 3fffffff", addr2); else n_pass++;
    tick();
    n_chk++; if (id2 !== {30'h0, 32'h3FFF_FFFF}) $display("FAIL wrap_id0: got %h want %h", id2, {30'h0, 32'h3FFF_FFFF}); else n_pass++;
    n_chk++; if (idv2 !== 1'b1) $display("FAIL wrap_valid: got %h want 1", idv2); else n_pass++;
    n_chk++; if (addr2 !== 30'h0) $display("FAIL wrap_addr1: got %h want 0", addr2); else n_pass++;
    tick();
    n_chk++; if (id2 !== {30'h1, 32'h0}) $display("FAIL wrap_id1: got %h want %h", id2, {30'h1, 32'h0}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_redirect_ack();
    test_drop();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
